// File: rtl/counter_arb_pkg.sv
// -----------------------------------------------------------------------------
// counter_arb_pkg
// Shared definitions for counter_step_arbiter.
// Contents:
//   arb_state_t  - FSM state encoding (IDLE=0, GRANT=1, RUN=2, DONE=3)
//   DEF_NUM_REQ  - default number of requesters
//   DEF_LEN_W    - default width of step-length requests and wrap count
// -----------------------------------------------------------------------------
package counter_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_LEN_W   = 4;

endpackage

// File: rtl/counter_step_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker: selects the first set request bit
// at or after ptr, wrapping past the top index back to 0. With ptr tied to 0
// it degenerates into a lowest-index fixed-priority picker.
// Ports:
//   req    [NUM_REQ-1:0] in  request vector
//   ptr    [IDX_W-1:0]   in  index that has highest priority this cycle
//   onehot [NUM_REQ-1:0] out one-hot winner (all zero when no request)
//   idx    [IDX_W-1:0]   out winner index (0 when no request)
//   any                  out at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int                 cand;
    logic [IDX_W-1:0]   cand_idx;

    // Scan candidates in priority order starting at ptr; the first hit wins.
    always_comb begin
        onehot   = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any = 1'b1;
                idx = cand_idx;
            end else begin
                any = any;
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/counter_step_arbiter.sv
// -----------------------------------------------------------------------------
// counter_step_arbiter
// Shares one external two-bit counter among NUM_REQ requesters. A granted
// requester receives a burst of exactly req_len counter steps (cnt_x high);
// completion is signalled with done together with the counter's final state
// and the number of wraps observed during the burst.
//
// Configuration macro:
//   COUNTER_ARB_FIXED_PRIO_EN - when defined, the lowest set request index
//                               always wins and no rotating pointer exists.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   req          in   [NUM_REQ] per-requester request level
//   req_len      in   [NUM_REQ*LEN_W] step counts, requester i at [i*LEN_W +: LEN_W]
//   gnt          out  [NUM_REQ] registered one-hot grant
//   busy         out  FSM not idle
//   done         out  one-cycle completion pulse
//   final_state  out  [2] {A,B} after the burst, held until the next done
//   wrap_cnt     out  [LEN_W] saturating wrap count of the burst, held likewise
//   cnt_x        out  step enable to the counter
//   cnt_a, cnt_b in   counter state bits (A = MSB)
//   cnt_z        in   counter wrap flag
// -----------------------------------------------------------------------------
module counter_step_arbiter
    import counter_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               final_state,
    output logic [LEN_W-1:0]         wrap_cnt,
    output logic                     cnt_x,
    input  logic                     cnt_a,
    input  logic                     cnt_b,
    input  logic                     cnt_z
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           state_r;
    logic [NUM_REQ-1:0]   gnt_r;
    logic [IDX_W-1:0]     win_idx_r;
    logic [LEN_W-1:0]     remaining_r;
    logic [LEN_W-1:0]     wrap_acc_r;
    logic [1:0]           final_state_r;
    logic [LEN_W-1:0]     wrap_cnt_r;

    logic [IDX_W-1:0]     ptr_s;
    logic [NUM_REQ-1:0]   pick_onehot_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic                 pick_any_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_s),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

`ifdef COUNTER_ARB_FIXED_PRIO_EN
    // Fixed priority: scanning always starts at index 0.
    assign ptr_s = '0;
`else
    logic [IDX_W-1:0] ptr_r;

    // Rotating pointer: moves just past the requester that was served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (state_r == ST_DONE) begin
            ptr_r <= (win_idx_r == IDX_W'(NUM_REQ - 1)) ? '0 : (win_idx_r + IDX_W'(1));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`endif

    // Arbitration / burst FSM with its datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            gnt_r         <= '0;
            win_idx_r     <= '0;
            remaining_r   <= '0;
            wrap_acc_r    <= '0;
            final_state_r <= 2'b00;
            wrap_cnt_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        state_r     <= ST_GRANT;
                        gnt_r       <= pick_onehot_s;
                        win_idx_r   <= pick_idx_s;
                        remaining_r <= req_len[pick_idx_s*LEN_W +: LEN_W];
                        wrap_acc_r  <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // A zero-length request skips RUN entirely.
                    state_r <= (remaining_r != '0) ? ST_RUN : ST_DONE;
                end
                ST_RUN: begin
                    remaining_r <= remaining_r - LEN_W'(1);
                    if (cnt_z && (wrap_acc_r != '1)) begin
                        wrap_acc_r <= wrap_acc_r + LEN_W'(1);
                    end else begin
                        wrap_acc_r <= wrap_acc_r;
                    end
                    state_r <= (remaining_r == LEN_W'(1)) ? ST_DONE : ST_RUN;
                end
                ST_DONE: begin
                    state_r       <= ST_IDLE;
                    gnt_r         <= '0;
                    final_state_r <= {cnt_a, cnt_b};
                    wrap_cnt_r    <= wrap_acc_r;
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= '0;
                end
            endcase
        end
    end

    assign gnt   = gnt_r;
    assign busy  = (state_r != ST_IDLE);
    assign done  = (state_r == ST_DONE);
    assign cnt_x = (state_r == ST_RUN);

    // Results become visible during DONE itself, before the holding registers load.
    assign final_state = (state_r == ST_DONE) ? {cnt_a, cnt_b} : final_state_r;
    assign wrap_cnt    = (state_r == ST_DONE) ? wrap_acc_r     : wrap_cnt_r;

endmodule

// File: tb/tb_counter_step_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_step_arbiter
// Bench for counter_step_arbiter: models the external two-bit counter and
// predicts grants, burst timing and results from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_counter_step_arbiter;

    localparam int NR = 4;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     gnt;
    logic              busy;
    logic              done;
    logic [1:0]        final_state;
    logic [LW-1:0]     wrap_cnt;
    logic              cnt_x;
    logic              cnt_a;
    logic              cnt_b;
    logic              cnt_z;

    // Counter model
    logic [1:0]        cnt_q;
    logic              cnt_load;
    logic [1:0]        cnt_load_val;
    logic              z_force;

    int n_tests = 0;
    int n_fail  = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (cnt_load) cnt_q <= cnt_load_val;
        else if (cnt_x) cnt_q <= cnt_q + 2'd1;
    end

    assign cnt_a = cnt_q[1];
    assign cnt_b = cnt_q[0];
    assign cnt_z = z_force | (cnt_x & (cnt_q == 2'd3));

    counter_step_arbiter #(.NUM_REQ(NR), .LEN_W(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_len     (req_len),
        .gnt         (gnt),
        .busy        (busy),
        .done        (done),
        .final_state (final_state),
        .wrap_cnt    (wrap_cnt),
        .cnt_x       (cnt_x),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b),
        .cnt_z       (cnt_z)
    );

    function automatic int model_pick(input logic [NR-1:0] r, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int c;
            c = (ptr + k) % NR;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic load_counter(input logic [1:0] v);
        cnt_load = 1'b1;
        cnt_load_val = v;
        @(negedge clk);
        cnt_load = 1'b0;
    endtask

    // Runs one burst from an IDLE negedge with req already driven and checks it
    // cycle by cycle; ends on the IDLE negedge after DONE.
    task automatic observe_burst(input bit drop, input bit zf);
        int win, len, start, exp_fs, exp_wc;
        logic [NR-1:0] exp_gnt;
        logic [LW-1:0] len_v;
`ifdef COUNTER_ARB_FIXED_PRIO_EN
        win = model_pick(req, 0);
`else
        win = model_pick(req, model_ptr);
`endif
        n_tests++;
        if (win < 0) begin
            n_fail++;
            $display("FAIL burst_setup: got no request, required at least one");
            return;
        end
        len_v = req_len[win*LW +: LW];
        len = int'(len_v);
        exp_gnt = '0;
        exp_gnt[win] = 1'b1;
        @(negedge clk);
        start = int'(cnt_q);
        n_tests += 4;
        if (gnt !== exp_gnt) begin n_fail++; $display("FAIL grant_gnt: got %b required %b", gnt, exp_gnt); end
        if (cnt_x !== 1'b0) begin n_fail++; $display("FAIL grant_x: got %b required 0", cnt_x); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL grant_busy: got %b required 1", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL grant_done: got %b required 0", done); end
        if (drop) begin
            req = '0;
            req_len = NR*LW'($urandom);
        end
        exp_wc = 0;
        for (int k = 0; k < len; k++) begin
            if (zf || ((start + k) % 4 == 3)) exp_wc++;
        end
        if (exp_wc > (1 << LW) - 1) exp_wc = (1 << LW) - 1;
        exp_fs = (start + len) % 4;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            n_tests += 3;
            if (cnt_x !== 1'b1) begin n_fail++; $display("FAIL run_x step %0d: got %b required 1", i, cnt_x); end
            if (gnt !== exp_gnt) begin n_fail++; $display("FAIL run_gnt: got %b required %b", gnt, exp_gnt); end
            if (done !== 1'b0) begin n_fail++; $display("FAIL run_done: got %b required 0", done); end
        end
        @(negedge clk);
        n_tests += 5;
        if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b required 1", done); end
        if (cnt_x !== 1'b0) begin n_fail++; $display("FAIL done_x: got %b required 0", cnt_x); end
        if (gnt !== exp_gnt) begin n_fail++; $display("FAIL done_gnt: got %b required %b", gnt, exp_gnt); end
        if (final_state !== 2'(exp_fs)) begin n_fail++; $display("FAIL done_final: got %0d required %0d", final_state, exp_fs); end
        if (wrap_cnt !== LW'(exp_wc)) begin n_fail++; $display("FAIL done_wrap: got %0d required %0d", wrap_cnt, exp_wc); end
        @(negedge clk);
        n_tests += 5;
        if (done !== 1'b0) begin n_fail++; $display("FAIL idle_done: got %b required 0", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b required 0", busy); end
        if (gnt !== '0) begin n_fail++; $display("FAIL idle_gnt: got %b required 0", gnt); end
        if (final_state !== 2'(exp_fs)) begin n_fail++; $display("FAIL held_final: got %0d required %0d", final_state, exp_fs); end
        if (wrap_cnt !== LW'(exp_wc)) begin n_fail++; $display("FAIL held_wrap: got %0d required %0d", wrap_cnt, exp_wc); end
        model_ptr = (win + 1) % NR;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111;
        req_len = {NR{4'd3}};
        z_force = 1'b0;
        cnt_load = 1'b1;
        cnt_load_val = 2'd0;
        repeat (2) begin
            @(negedge clk);
            n_tests += 6;
            if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b required 0000", gnt); end
            if (cnt_x !== 1'b0) begin n_fail++; $display("FAIL reset_x: got %b required 0", cnt_x); end
            if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
            if (final_state !== 2'b00) begin n_fail++; $display("FAIL reset_final: got %b required 00", final_state); end
            if (wrap_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_wrap: got %0d required 0", wrap_cnt); end
        end
        cnt_load = 1'b0;
        req = '0;
        rst_n = 1'b1;
        model_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        load_counter(2'd0);
        req_len[0 +: LW] = 4'd5;
        req = 4'b0001;
        observe_burst(1'b0, 1'b0);
        req = '0;
        n_tests += 2;
        if (final_state !== 2'b01) begin n_fail++; $display("FAIL single_final: got %b required 01", final_state); end
        if (wrap_cnt !== 4'd1) begin n_fail++; $display("FAIL single_wrap: got %0d required 1", wrap_cnt); end
    endtask

    task automatic test_back_to_back();
        req_len = {4'd2, 4'd2, 4'd2, 4'd2};
        req = 4'b1011;
        repeat (4) observe_burst(1'b0, 1'b0);
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        load_counter(2'd2);
        req_len[2*LW +: LW] = 4'd0;
        req = 4'b0100;
        observe_burst(1'b0, 1'b0);
        req = '0;
        n_tests += 2;
        if (final_state !== 2'b10) begin n_fail++; $display("FAIL zero_final: got %b required 10", final_state); end
        if (wrap_cnt !== 4'd0) begin n_fail++; $display("FAIL zero_wrap: got %0d required 0", wrap_cnt); end
    endtask

    task automatic test_wrap();
        load_counter(2'd3);
        req_len[3*LW +: LW] = 4'd15;
        req = 4'b1000;
        observe_burst(1'b0, 1'b0);
        req = '0;
        n_tests += 2;
        if (wrap_cnt !== 4'd4) begin n_fail++; $display("FAIL wrap_cnt15: got %0d required 4", wrap_cnt); end
        if (final_state !== 2'b10) begin n_fail++; $display("FAIL wrap_final15: got %b required 10", final_state); end
        // Wrap flag held high for the whole burst drives the count to all-ones.
        load_counter(2'd0);
        req_len[1*LW +: LW] = 4'd15;
        req = 4'b0010;
        z_force = 1'b1;
        observe_burst(1'b1, 1'b1);
        z_force = 1'b0;
        req = '0;
        n_tests++;
        if (wrap_cnt !== 4'hF) begin n_fail++; $display("FAIL wrap_sat: got %0d required 15", wrap_cnt); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            load_counter(2'($urandom_range(0, 3)));
            req_len = NR*LW'($urandom);
            req = 4'($urandom_range(1, 15));
            observe_burst(1'($urandom_range(0, 1)), 1'b0);
            req = '0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        load_counter(2'd0);
        req_len[0 +: LW] = 4'd8;
        req = 4'b0001;
        @(negedge clk);  // GRANT
        repeat (3) @(negedge clk);  // third RUN cycle
        n_tests++;
        if (cnt_x !== 1'b1) begin n_fail++; $display("FAIL abort_run_x: got %b required 1", cnt_x); end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests += 6;
        if (cnt_x !== 1'b0) begin n_fail++; $display("FAIL abort_x: got %b required 0", cnt_x); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b required 0", done); end
        if (gnt !== 4'b0000) begin n_fail++; $display("FAIL abort_gnt: got %b required 0000", gnt); end
        if (final_state !== 2'b00) begin n_fail++; $display("FAIL abort_final: got %b required 00", final_state); end
        if (cnt_q !== 2'd3) begin n_fail++; $display("FAIL abort_counter: got %0d required 3", cnt_q); end
        rst_n = 1'b1;
        req = '0;
        model_ptr = 0;
        repeat (4) begin
            @(negedge clk);
            n_tests += 2;
            if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b required 0", done); end
            if (cnt_x !== 1'b0) begin n_fail++; $display("FAIL abort_idle_x: got %b required 0", cnt_x); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_len();
        test_wrap();
        test_random();
        test_reset_mid_burst();
        // Arbitration resumes normally after an aborted burst.
        req_len = {4'd1, 4'd3, 4'd2, 4'd1};
        req = 4'b0110;
        repeat (3) observe_burst(1'b0, 1'b0);
        req = '0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_step_arbiter.md
Name: counter_step_arbiter

Overview:
- Shares one external two-bit counter (step input x; state outputs A,B; wrap flag z) among NUM_REQ requesters.
- Each requester asks for a burst of N counter steps.
- The arbiter grants requesters one at a time (round-robin) and drives the counter's x input high for exactly N cycles.
- It reports completion with the counter's final state and the number of wraps seen during the burst.
- Sits between the requesting control blocks and the counter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LEN_W, 4, width of each step-length request and of the wrap count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  NUM_REQ  per-requester request level.
- req_len  input  NUM_REQ*LEN_W  flattened step counts; requester i uses bits [i*LEN_W +: LEN_W].
- gnt  output  NUM_REQ  one-hot grant, registered.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- final_state  output  2  {A,B} after the burst; valid when done=1, held until the next done.
- wrap_cnt  output  LEN_W  count of z=1 cycles during the burst, saturating at all-ones; held like final_state.
- cnt_x  output  1  step enable to the counter.
- cnt_a, cnt_b  input  1 each  counter state bits (A = MSB).
- cnt_z  input  1  counter wrap flag: 1 when x=1 and {A,B}=3.

Behaviour:
Counter contract:
- When x=1 at a rising edge, {A,B} increments modulo 4.
- z is combinational and is 1 only when x=1 and {A,B}=3.

Reset:
- All registered state clears when rst_n=0 at an edge: state=IDLE, gnt=0, done=0, final_state=0, wrap_cnt=0, rr pointer=0, remaining=0.
- cnt_x is decoded from state, so it is 0 from the first cycle after reset.
- Reset mid-burst aborts the burst immediately. No done pulse is issued. The counter is left where it stopped.

FSM states: IDLE, GRANT, RUN, DONE.
- IDLE: if any req bit is high, pick the winner = first set bit at or after the rr pointer (wrapping). Next state GRANT; gnt = onehot(winner); latch remaining = req_len[winner]; clear the wrap accumulator.
- GRANT: one cycle, gnt held, cnt_x=0. Next state RUN if remaining != 0, else DONE.
- RUN: cnt_x=1. Each cycle: remaining decrements; wrap accumulator increments (saturating) when cnt_z=1. When remaining==1, next state is DONE. RUN therefore lasts exactly req_len cycles.
- DONE: one cycle.
  - done=1.
  - final_state and wrap_cnt registers update on the edge leaving DONE; they are also visible combinationally during DONE.
  - Implementation: final_state is driven as a mux: {cnt_a,cnt_b} in DONE, else the held register.
  - gnt drops to 0 the next cycle.
  - rr pointer = winner+1 mod NUM_REQ.
  - Next state is IDLE.

Latency and boundary cases:
- Request-to-first-step latency is 2 cycles (IDLE edge, GRANT).
- Minimum turnaround between bursts is 3 idle-x cycles (GRANT, DONE, IDLE).
- len=0: GRANT goes straight to DONE; wrap_cnt=0; final_state equals the unchanged counter state.
- req deasserted during GRANT/RUN: ignored; the burst completes.
- req_len changes after latch: ignored.
- Requester holding req continuously: served again only after every other active requester has been served once.
- Simultaneous requests: resolved by the rr pointer only.

Optional Feature:
- COUNTER_ARB_FIXED_PRIO_EN
  - Defined: winner is always the lowest set req index; the rr pointer is not implemented (tie to 0).
  - Undefined: round-robin as above.

Decomposition:
- Package counter_arb_pkg: state encoding constants (IDLE=2'd0, GRANT=2'd1, RUN=2'd2, DONE=2'd3) and default NUM_REQ/LEN_W.
- Sub-module rr_pick: combinational, inputs req and pointer, outputs one-hot winner and index. Used by both arbitration modes, with the pointer forced to 0 under the macro.

Test Plan:
1. Reset with rst_n=0 for 2 cycles while req=4'b1111 → gnt=0, cnt_x=0, done=0, busy=0 throughout reset.
2. Counter at 0, req[0]=1, len=5 → cnt_x high exactly 5 consecutive cycles starting 2 cycles after the req edge; done pulse with final_state=2'b01, wrap_cnt=1; gnt=4'b0001 during GRANT..DONE.
3. req=4'b1011 held, all len=2 → grants in order 0,1,3,0; cnt_x asserted exactly 2 cycles per grant; 3-cycle gaps between bursts.
4. req[2] with len=0 → GRANT then DONE with no cnt_x; wrap_cnt=0; final_state equals the prior counter state.
5. len=15 from state 3 → wrap_cnt=4, final_state=2'b10. With LEN_W=2 the same counter behaviour (len=3 from state 3) gives wrap_cnt=1. Separately, force 3 wraps and check wrap_cnt saturates at 2'b11.
6. rst_n pulled low in the 3rd RUN cycle → cnt_x=0 next cycle, no done pulse, state IDLE. Repeat with COUNTER_ARB_FIXED_PRIO_EN defined and req=4'b0110 held → req 1 is always granted.
